led_bus_arb: RTL and testbench

- Two-master arbiter that shares the single slave port of the memory-mapped seven-segment LED peripheral.
- Master 0 is the CPU data bus; master 1 is a secondary requester, such as a timer or debug engine that updates the display.
- Serialises accesses with a req/ack handshake, drives the peripheral's ADD/DAT_I/Wr/BE, and returns DAT_O to the winner.
- Round-robin fairness, with an optional bounded lock for back-to-back accesses.

---
 rtl/led_bus_arb.sv | 167 ++++++++++++++++
 tb/tb_led_bus_arb.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_bus_arb.sv
// led_bus_arb: two-master arbiter for the seven-segment LED peripheral slave port.
// Each transaction has three cycles: IDLE (arbitrate), XFER (one Wr/read cycle
// on the slave) and DONE (one-cycle ack to the owner). Arbitration is round-robin
// with an optional lock that lets the previous owner keep the port for up to
// MAX_LOCK further grants.
// Build option: define LED_ARB_PRIO_EN for fixed priority (m0 wins ties) in
// place of round-robin. The lock still applies in that mode.
module led_bus_arb #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 4
) (
  input  logic            clk,
  input  logic            RST,
  input  logic            m0_req,
  input  logic            m0_lock,
  input  logic [AW-1:0]   m0_add,
  input  logic [DW-1:0]   m0_dat,
  input  logic            m0_wr,
  input  logic [DW/8-1:0] m0_be,
  output logic            m0_ack,
  output logic [DW-1:0]   m0_rdat,
  input  logic            m1_req,
  input  logic            m1_lock,
  input  logic [AW-1:0]   m1_add,
  input  logic [DW-1:0]   m1_dat,
  input  logic            m1_wr,
  input  logic [DW/8-1:0] m1_be,
  output logic            m1_ack,
  output logic [DW-1:0]   m1_rdat,
  output logic [AW-1:0]   s_add,
  output logic [DW-1:0]   s_dat,
  output logic            s_wr,
  output logic [DW/8-1:0] s_be,
  input  logic [DW-1:0]   s_dat_o,
  output logic [1:0]      gnt
);

  localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t     state, state_nxt;
  logic       owner;      // 0 = m0, 1 = m1; valid from XFER through DONE
  logic       last;       // last-served master
  logic       prev_vld;   // a transaction has completed since reset
  logic [7:0] lock_cnt;

  logic       grant_vld;
  logic       grant_sel;
  logic [7:0] lock_cnt_nxt;
  logic [1:0] req;
  logic [1:0] lck;
  logic       prev_hold;
  logic       other_req;

  assign req = {m1_req, m0_req};
  assign lck = {m1_lock, m0_lock};

  // Next-state and grant decision; the grant is only acted on in IDLE.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_nxt    = state;
    grant_vld    = 1'b0;
    grant_sel    = owner;
    lock_cnt_nxt = lock_cnt;
    prev_hold    = prev_vld && req[last] && lck[last];
    other_req    = req[~last];
    case (state)
      IDLE: begin
        if (|req) begin
          grant_vld = 1'b1;
          state_nxt = XFER;
          if (prev_hold && (lock_cnt < MAX_LOCK_C)) begin
            // Locked regrant within budget.
            grant_sel    = last;
            lock_cnt_nxt = lock_cnt + 8'd1;
          end else if (prev_hold && !other_req) begin
            // Budget used up but nobody else wants the port: keep it, count saturates.
            grant_sel = last;
          end else begin
            lock_cnt_nxt = 8'd0;
            if (prev_hold) begin
              // Forced release to the other requester.
              grant_sel = ~last;
            end else if (req == 2'b01) begin
              grant_sel = 1'b0;
            end else if (req == 2'b10) begin
              grant_sel = 1'b1;
            end else begin
`ifdef LED_ARB_PRIO_EN
              grant_sel = 1'b0;
`else
              grant_sel = ~last;
`endif
            end
          end
        end
      end
      XFER:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and all registered outputs; reset is synchronous.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!RST) begin
      state    <= IDLE;
      owner    <= 1'b0;
      last     <= 1'b1;
      prev_vld <= 1'b0;
      lock_cnt <= 8'd0;
      gnt      <= 2'b00;
      s_add    <= '0;
      s_dat    <= '0;
      s_wr     <= 1'b0;
      s_be     <= '0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdat  <= '0;
      m1_rdat  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            owner    <= grant_sel;
            lock_cnt <= lock_cnt_nxt;
            gnt      <= grant_sel ? 2'b10 : 2'b01;
            s_add    <= grant_sel ? m1_add : m0_add;
            s_dat    <= grant_sel ? m1_dat : m0_dat;
            s_wr     <= grant_sel ? m1_wr  : m0_wr;
            s_be     <= grant_sel ? m1_be  : m0_be;
          end
        end
        XFER: begin
          s_add    <= '0;
          s_dat    <= '0;
          s_wr     <= 1'b0;
          s_be     <= '0;
          last     <= owner;
          prev_vld <= 1'b1;
          if (owner) begin
            m1_rdat <= s_dat_o;
            m1_ack  <= 1'b1;
          end else begin
            m0_rdat <= s_dat_o;
            m0_ack  <= 1'b1;
          end
        end
        DONE: begin
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
          gnt    <= 2'b00;
        end
        default: begin
          gnt <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_bus_arb.sv
// tb_led_bus_arb: self-checking bench for led_bus_arb. A small LED peripheral
// model sits on the slave port; a transaction-level reference model predicts
// the winner of each arbitration round, the slave cycle and the returned data.
module tb_led_bus_arb;

  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int BW       = DW / 8;
  localparam int MAX_LOCK = 4;
  localparam logic [AW-1:0] LED_ADD_2 = 32'h0000_0008;
`ifdef LED_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            RST = 1'b0;
  logic            m0_req, m0_lock, m0_wr, m0_ack;
  logic            m1_req, m1_lock, m1_wr, m1_ack;
  logic [AW-1:0]   m0_add, m1_add, s_add;
  logic [DW-1:0]   m0_dat, m1_dat, m0_rdat, m1_rdat, s_dat, s_dat_o;
  logic [BW-1:0]   m0_be, m1_be, s_be;
  logic            s_wr;
  logic [1:0]      gnt;

  // Master-side stimulus, indexed by master number.
  logic            p_req  [2];
  logic            p_lock [2];
  logic [AW-1:0]   p_add  [2];
  logic [DW-1:0]   p_dat  [2];
  logic            p_wr   [2];
  logic [BW-1:0]   p_be   [2];

  assign m0_req = p_req[0];  assign m1_req = p_req[1];
  assign m0_lock = p_lock[0]; assign m1_lock = p_lock[1];
  assign m0_add = p_add[0];  assign m1_add = p_add[1];
  assign m0_dat = p_dat[0];  assign m1_dat = p_dat[1];
  assign m0_wr  = p_wr[0];   assign m1_wr  = p_wr[1];
  assign m0_be  = p_be[0];   assign m1_be  = p_be[1];

  always #5 clk = ~clk;

  led_bus_arb #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .RST(RST),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_add(m0_add), .m0_dat(m0_dat),
    .m0_wr(m0_wr), .m0_be(m0_be), .m0_ack(m0_ack), .m0_rdat(m0_rdat),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_add(m1_add), .m1_dat(m1_dat),
    .m1_wr(m1_wr), .m1_be(m1_be), .m1_ack(m1_ack), .m1_rdat(m1_rdat),
    .s_add(s_add), .s_dat(s_dat), .s_wr(s_wr), .s_be(s_be),
    .s_dat_o(s_dat_o), .gnt(gnt)
  );

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old_v, logic [DW-1:0] new_v,
                                          logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old_v;
    for (int b = 0; b < BW; b++)
      if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] init_word(int i);
    case (i)
      0:       return 32'hA5A5_0001;
      1:       return 32'h0000_BEEF;
      2:       return 32'd4321;
      default: return 32'h1357_9BDF;
    endcase
  endfunction

  // Peripheral model: four words, write-through read during a write cycle.
  logic [DW-1:0] pmem [4];
  logic [1:0]    pidx;
  assign pidx    = s_add[3:2];
  assign s_dat_o = s_wr ? merge(pmem[pidx], s_dat, s_be) : pmem[pidx];

  always @(posedge clk) begin
    if (!RST) begin
      for (int i = 0; i < 4; i++) pmem[i] <= init_word(i);
    end else if (s_wr) begin
      pmem[pidx] <= merge(pmem[pidx], s_dat, s_be);
    end
  end

  // Reference model state.
  int            m_last;
  bit            m_pv;
  int            m_cnt;
  logic [DW-1:0] ref_mem  [4];
  logic [DW-1:0] exp_rdat [2];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last = 1;
    m_pv   = 1'b0;
    m_cnt  = 0;
    for (int i = 0; i < 4; i++) ref_mem[i] = init_word(i);
    exp_rdat[0] = '0;
    exp_rdat[1] = '0;
  endtask

  // Who wins the next IDLE sample, from the arbitration rules; -1 if nobody asks.
  task automatic model_pick(output int win);
    int prv, oth;
    bit hold;
    win = -1;
    if (!p_req[0] && !p_req[1]) return;
    prv  = m_last;
    oth  = 1 - prv;
    hold = m_pv && p_req[prv] && p_lock[prv];
    if (hold && m_cnt < MAX_LOCK) begin
      win = prv;
      m_cnt++;
    end else if (hold && !p_req[oth]) begin
      win = prv;
    end else begin
      m_cnt = 0;
      if (hold)                       win = oth;
      else if (p_req[0] && p_req[1])  win = PRIO ? 0 : oth;
      else                            win = p_req[0] ? 0 : 1;
    end
    m_last = win;
    m_pv   = 1'b1;
  endtask

  // One arbitration round starting in IDLE: one cycle if idle, else three.
  task automatic run_round(output int win);
    logic [DW-1:0] exp_d;
    int idx, oth;
    model_pick(win);
    @(posedge clk); @(negedge clk);
    if (win < 0) begin
      check("idle_gnt", gnt, 2'b00);
      check("idle_wr", s_wr, 1'b0);
      return;
    end
    oth = 1 - win;
    idx = int'(p_add[win][3:2]);
    exp_d = p_wr[win] ? merge(ref_mem[idx], p_dat[win], p_be[win]) : ref_mem[idx];
    // XFER cycle
    check("xfer_gnt", gnt, (win == 1) ? 2'b10 : 2'b01);
    check("xfer_wr", s_wr, p_wr[win]);
    check("xfer_add", s_add, p_add[win]);
    check("xfer_dat", s_dat, p_dat[win]);
    check("xfer_be", s_be, p_be[win]);
    check("xfer_acks", {m1_ack, m0_ack}, 2'b00);
    if (p_wr[win]) ref_mem[idx] = exp_d;
    exp_rdat[win] = exp_d;
    @(posedge clk); @(negedge clk);
    // DONE cycle
    check("done_gnt", gnt, (win == 1) ? 2'b10 : 2'b01);
    check("done_acks", {m1_ack, m0_ack}, (win == 1) ? 2'b10 : 2'b01);
    check("done_rdat_own", (win == 1) ? m1_rdat : m0_rdat, exp_rdat[win]);
    check("done_rdat_oth", (oth == 1) ? m1_rdat : m0_rdat, exp_rdat[oth]);
    check("done_slave", {s_wr, s_add, s_dat, s_be}, '0);
    @(posedge clk); @(negedge clk);
    // back in IDLE
    check("idle_gnt", gnt, 2'b00);
    check("idle_acks", {m1_ack, m0_ack}, 2'b00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    RST = 1'b0;
    for (int m = 0; m < 2; m++) begin
      p_req[m] = 0; p_lock[m] = 0; p_add[m] = '0; p_dat[m] = '0; p_wr[m] = 0; p_be[m] = '0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    RST = 1'b1;
  endtask

  task automatic gen_req(input int m);
    p_req[m]  = 1'b1;
    p_lock[m] = ($urandom_range(0, 2) == 0);
    p_add[m]  = AW'($urandom_range(0, 3) * 4);
    p_dat[m]  = $urandom;
    p_wr[m]   = 1'($urandom_range(0, 1));
    p_be[m]   = BW'($urandom_range(1, (1 << BW) - 1));
  endtask

  task automatic set_req(input int m, input logic lk, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic w, input logic [BW-1:0] be);
    p_req[m] = 1'b1; p_lock[m] = lk; p_add[m] = a; p_dat[m] = d; p_wr[m] = w; p_be[m] = be;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int seq [6];

    // Reset state
    do_reset();
    check("rst_gnt", gnt, 2'b00);
    check("rst_slave", {s_wr, s_add, s_dat, s_be}, '0);
    check("rst_acks", {m1_ack, m0_ack}, 2'b00);
    check("rst_rdat", {m1_rdat, m0_rdat}, '0);

    // m0 write, then read it back
    set_req(0, 1'b0, LED_ADD_2, 32'h1234, 1'b1, 4'hF);
    run_round(w);
    check("wr_winner", w, 0);
    p_req[0] = 1'b0;
    set_req(0, 1'b0, LED_ADD_2, 32'h0, 1'b0, 4'hF);
    run_round(w);
    check("wr_readback", m0_rdat, 32'h1234);
    p_req[0] = 1'b0;

    // m1 read after reset
    do_reset();
    set_req(1, 1'b0, LED_ADD_2, 32'h0, 1'b0, 4'hF);
    run_round(w);
    check("rd_winner", w, 1);
    check("rd_m1_rdat", m1_rdat, 32'd4321);
    check("rd_m0_rdat", m0_rdat, 32'd0);
    p_req[1] = 1'b0;

    // Both requesting continuously, no lock
    do_reset();
    set_req(0, 1'b0, 32'h0, 32'h1111_0000, 1'b1, 4'h3);
    set_req(1, 1'b0, 32'h4, 32'h0, 1'b0, 4'hF);
    for (int i = 0; i < 4; i++) begin
      run_round(w);
      check("alt_winner", w, PRIO ? 0 : (i % 2));
    end

    // m0 locked against a requesting m1: 1 + MAX_LOCK grants, then release
    do_reset();
    set_req(0, 1'b1, 32'h8, 32'h0, 1'b0, 4'hF);
    set_req(1, 1'b0, 32'hC, 32'hCAFE_F00D, 1'b1, 4'hF);
    for (int i = 0; i < 6; i++) run_round(seq[i]);
    for (int i = 0; i < 6; i++) check("lock_seq", seq[i], (i < 5) ? 0 : 1);
    // Counter cleared: m0 gets the full budget again.
    for (int i = 0; i < 5; i++) begin
      run_round(w);
      check("lock_again", w, 0);
    end

    // Reset asserted during XFER
    do_reset();
    set_req(0, 1'b0, 32'h4, 32'h7777_7777, 1'b1, 4'hF);
    set_req(1, 1'b0, 32'h0, 32'h0, 1'b0, 4'hF);
    @(posedge clk); @(negedge clk);
    check("mid_xfer_gnt", gnt, 2'b01);
    RST = 1'b0;
    @(posedge clk); @(negedge clk);
    check("mid_rst_gnt", gnt, 2'b00);
    check("mid_rst_wr", s_wr, 1'b0);
    check("mid_rst_acks", {m1_ack, m0_ack}, 2'b00);
    RST = 1'b1;
    model_reset();
    run_round(w);
    check("mid_rst_first", w, 0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < 2; m++)
        if (!p_req[m] && $urandom_range(0, 3) != 0) gen_req(m);
      run_round(w);
      if (w >= 0 && $urandom_range(0, 3) != 0) p_req[w] = 1'b0;
      else if (w >= 0) p_req[w] = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
